demux_1_to_16_buf: RTL and testbench
====================================

# demux_1_to_16_buf

Buffered 1-to-N stream demultiplexer: accepts one BIT_WIDTH word per cycle on a valid/ready input and steers it to one of NUM_OUTPUTS output lanes, each held in a one-entry output register with its own valid/ready handshake. It is the distribution-side counterpart of the N-to-1 select muxes. It fans a single neuron/synapse word stream out to the per-lane consumers of the datapath. Destination comes from an explicit select or from an internal round-robin pointer.

## Interface
- BIT_WIDTH, 16, width of one data word
- SEL_WIDTH, 4, width of lane select / pointer
- NUM_OUTPUTS, 1 << SEL_WIDTH, number of output lanes (always a power of two)

- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  input word present
- o_ready  output  1  input word accepted this cycle when i_valid & o_ready
- i_A  input  BIT_WIDTH  input word
- i_sel  input  SEL_WIDTH  destination lane when i_auto = 0
- i_auto  input  1  1 = destination is internal pointer o_ptr
- i_bcast  input  1  broadcast request (only active with DEMUX_BROADCAST_EN)
- o_valid  output  NUM_OUTPUTS  per-lane word held
- i_ready  input  NUM_OUTPUTS  per-lane consumer ready
- o_B  output  BIT_WIDTH*NUM_OUTPUTS  lane k data at bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
- o_ptr  output  SEL_WIDTH  current round-robin pointer

## Operation
- dest = i_auto ? o_ptr : i_sel; sampled only when the input handshake completes.
- Lane k is free when ~o_valid[k] | i_ready[k] (a same-cycle drain frees it).
- o_ready = lane dest is free. o_ready depends combinationally on i_sel, i_auto, o_ptr, i_ready and lane state, never on i_valid.
- Accept (i_valid & o_ready): lane dest register <= i_A, o_valid[dest] <= 1.
- Lane k drain (o_valid[k] & i_ready[k]) without a load in the same cycle: o_valid[k] <= 0. Drain and load in the same cycle: o_valid[k] stays 1 with the new word.
- Pointer: increments by 1 on each accept with i_auto = 1. Wraps NUM_OUTPUTS-1 -> 0. Unchanged on accepts with i_auto = 0 and when no accept occurs.
- Lanes are independent: a stalled lane blocks the input only when it is the current destination.
- o_B[k] holds its value while o_valid[k] & ~i_ready[k]. Its value while o_valid[k] = 0 is the last word loaded (0 after reset).

## Timing
- Reset (asynchronous assert, synchronous release): o_valid = 0, all o_B lanes = 0, o_ptr = 0. o_ready then reflects the now-empty lanes (1).
- Latency: word accepted in cycle n appears on o_B/o_valid in cycle n+1.
- Throughput: 1 word/cycle sustained while the destination lane drains every cycle.
- Reset mid-operation discards all held words and the pointer, with no partial handshake completion.

## Configuration
- DEMUX_BROADCAST_EN defined: with i_bcast = 1, dest is all lanes. o_ready = AND of all lanes free. Accept loads i_A into every lane and sets every o_valid bit. o_ptr is unchanged, and i_bcast overrides i_auto and i_sel.
- Not defined: i_bcast is ignored (port kept, unused). Behaviour is identical to i_bcast = 0.

## Structure
- Shared package holds the default BIT_WIDTH/SEL_WIDTH constants and the lane-count derivation, reused by the mux family.
- One sub-module, lane_buf: a one-entry register with load, drain, valid and data, instantiated NUM_OUTPUTS times via generate. The top holds dest decode, o_ready, the pointer and the broadcast logic.

## Test plan
- Explicit select: i_auto = 0, i_sel = 3, i_A = 16'hA5A5, all i_ready = 0 -> o_valid = 16'h0008 next cycle, lane 3 = A5A5. A second word to lane 3 gets o_ready = 0. A word to lane 4 is accepted.
- Round robin: i_auto = 1, 17 back-to-back words 0..16, all i_ready = 1 -> lane k receives word k, lane 0 then receives 16, o_ptr sequence 0..15, 0, 1. No bubbles.
- Same-cycle drain and load: lane 2 full with 0x1111, i_ready[2] = 1, new word 0x2222 to lane 2 -> accepted. o_valid[2] stays 1 and o_B lane 2 = 0x2222 next cycle.
- Backpressure hold: lane 5 holds 0xBEEF, i_ready[5] = 0 for 10 cycles -> o_B lane 5 stable at 0xBEEF, o_valid[5] = 1 throughout.
- Reset mid-stream: assert i_rst_n = 0 asynchronously with 4 lanes full and o_ptr = 7 -> o_valid = 0, o_B = 0, o_ptr = 0 immediately, without waiting for a clock edge.
- With DEMUX_BROADCAST_EN: i_bcast = 1, i_A = 16'h00FF, one lane full and stalled -> o_ready = 0. After it drains, the word is accepted, o_valid = 16'hFFFF, every lane = 0x00FF, o_ptr unchanged.

Source files
------------

// File: rtl/demux_1_to_16_buf_pkg.sv
// demux_1_to_16_buf_pkg
// Shared constants for the demux / select-mux family: default word width,
// default select width and the lane-count derivation (always a power of two).
package demux_1_to_16_buf_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_SEL_WIDTH = 4;

  // Number of lanes addressed by a select of the given width.
  function automatic int lane_count(input int sel_width);
    return 32'sd1 << sel_width;
  endfunction

endpackage

// File: rtl/demux_1_to_16_buf_lane_buf.sv
// lane_buf
// One-entry output register for a single demux lane.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d this cycle (sets valid)
//   ready      : consumer ready; drains the held word when valid
//   d          : word to capture
//   valid      : a word is held
//   q          : held word (keeps the last loaded word after draining)
module lane_buf #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 ready,
  input  logic [BIT_WIDTH-1:0] d,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] q
);

  logic                 valid_r;
  logic [BIT_WIDTH-1:0] data_r;

  // Valid flag: a load wins over a same-cycle drain, so the lane stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data register: only changes on a load, otherwise holds the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {BIT_WIDTH{1'b0}};
    end else if (load) begin
      data_r <= d;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign q     = data_r;

endmodule

// File: rtl/demux_1_to_16_buf.sv
// demux_1_to_16_buf
// Buffered 1-to-N stream demultiplexer. One word per cycle arrives on a
// valid/ready input and is steered to one of NUM_OUTPUTS lanes, each a
// one-entry register with its own valid/ready handshake. The destination is
// i_sel, or the internal round-robin pointer o_ptr when i_auto = 1.
// Optional feature macro: DEMUX_BROADCAST_EN (i_bcast = 1 loads every lane).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: input handshake, i_A input word
//   i_sel, i_auto  : explicit destination / use round-robin pointer
//   i_bcast        : broadcast request (ignored without DEMUX_BROADCAST_EN)
//   o_valid/i_ready: per-lane output handshake
//   o_B            : lane k data at [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
//   o_ptr          : current round-robin pointer
module demux_1_to_16_buf
  import demux_1_to_16_buf_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter int NUM_OUTPUTS = lane_count(SEL_WIDTH)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [BIT_WIDTH-1:0]             i_A,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic                             i_auto,
  input  logic                             i_bcast,
  output logic [NUM_OUTPUTS-1:0]           o_valid,
  input  logic [NUM_OUTPUTS-1:0]           i_ready,
  output logic [BIT_WIDTH*NUM_OUTPUTS-1:0] o_B,
  output logic [SEL_WIDTH-1:0]             o_ptr
);

  logic [SEL_WIDTH-1:0]   ptr_r;
  logic [SEL_WIDTH-1:0]   dest_s;
  logic [NUM_OUTPUTS-1:0] lane_free_s;
  logic [NUM_OUTPUTS-1:0] dest_onehot_s;
  logic [NUM_OUTPUTS-1:0] load_s;
  logic                   bcast_s;
  logic                   ready_s;
  logic                   accept_s;

`ifdef DEMUX_BROADCAST_EN
  assign bcast_s = i_bcast;
`else
  // Port kept for interface compatibility; masked so it has no effect.
  assign bcast_s = i_bcast & 1'b0;
`endif

  // A lane can take a word if empty or being drained this very cycle.
  assign lane_free_s = ~o_valid | i_ready;

  // Destination select and its one-hot decode.
  always_comb begin
    dest_onehot_s = {NUM_OUTPUTS{1'b0}};
    if (i_auto) begin
      dest_s = ptr_r;
    end else begin
      dest_s = i_sel;
    end
    dest_onehot_s[dest_s] = 1'b1;
  end

  // Input ready never looks at i_valid, only at the addressed lane(s).
  always_comb begin
    if (bcast_s) begin
      ready_s = &lane_free_s;
    end else begin
      ready_s = lane_free_s[dest_s];
    end
  end

  assign accept_s = i_valid & ready_s;
  assign o_ready  = ready_s;

  // Per-lane load strobes.
  always_comb begin
    if (!accept_s) begin
      load_s = {NUM_OUTPUTS{1'b0}};
    end else if (bcast_s) begin
      load_s = {NUM_OUTPUTS{1'b1}};
    end else begin
      load_s = dest_onehot_s;
    end
  end

  // Round-robin pointer: advances only on auto-addressed, non-broadcast accepts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r <= {SEL_WIDTH{1'b0}};
    end else if (accept_s && i_auto && !bcast_s) begin
      ptr_r <= ptr_r + SEL_WIDTH'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign o_ptr = ptr_r;

  genvar k;
  generate
    for (k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
      lane_buf #(
        .BIT_WIDTH(BIT_WIDTH)
      ) u_lane (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .load (load_s[k]),
        .ready(i_ready[k]),
        .d    (i_A),
        .valid(o_valid[k]),
        .q    (o_B[k*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_1_to_16_buf.sv
// Self-checking bench for demux_1_to_16_buf: directed scenarios plus random
// traffic, with a per-lane expected-word queue filled on predicted accepts and
// emptied by a monitor whenever a lane handshake completes.
module tb_demux_1_to_16_buf;

  localparam int BW = 16;
  localparam int SW = 4;
  localparam int N  = 16;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [BW-1:0] i_a;
  logic [SW-1:0] i_sel;
  logic          i_auto;
  logic          i_bcast;
  logic [N-1:0]  o_valid;
  logic [N-1:0]  i_ready;
  logic [BW*N-1:0] o_b;
  logic [SW-1:0] o_ptr;

  int tests;
  int fails;

  // Reference state: words expected per lane (front = word on the lane now)
  logic [BW-1:0] lane_q [N][$];
  int            m_ptr;

  demux_1_to_16_buf dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_a),
    .i_sel  (i_sel),
    .i_auto (i_auto),
    .i_bcast(i_bcast),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_B    (o_b),
    .o_ptr  (o_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] lane_word(input int k);
    return o_b[k*BW +: BW];
  endfunction

  // Drive one cycle of inputs, check the visible state against the model and
  // record what the model says gets accepted at the coming edge.
  task automatic step(input logic v, input logic [BW-1:0] a, input logic [SW-1:0] sel,
                      input logic au, input logic bc, input logic [N-1:0] rdy);
    logic [N-1:0] exp_valid;
    logic         exp_ready;
    logic         is_bc;
    int           dest;
    @(negedge clk);
    i_valid = v; i_a = a; i_sel = sel; i_auto = au; i_bcast = bc; i_ready = rdy;
    #1;
    for (int k = 0; k < N; k++) exp_valid[k] = (lane_q[k].size() != 0);
    chk("o_valid", 32'(o_valid), 32'(exp_valid));
    chk("o_ptr", 32'(o_ptr), 32'(m_ptr));
`ifdef DEMUX_BROADCAST_EN
    is_bc = bc;
`else
    is_bc = 1'b0;
`endif
    dest = au ? m_ptr : int'(sel);
    if (is_bc) begin
      exp_ready = 1'b1;
      for (int k = 0; k < N; k++)
        if (lane_q[k].size() != 0 && !rdy[k]) exp_ready = 1'b0;
    end else begin
      exp_ready = (lane_q[dest].size() == 0) || rdy[dest];
    end
    chk("o_ready", 32'(o_ready), 32'(exp_ready));
    if (v && exp_ready) begin
      if (is_bc) begin
        for (int k = 0; k < N; k++) lane_q[k].push_back(a);
      end else begin
        lane_q[dest].push_back(a);
        if (au) m_ptr = (m_ptr + 1) % N;
      end
    end
  endtask

  // Monitor: every completed lane handshake must deliver the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (o_valid[k] && i_ready[k]) begin
          if (lane_q[k].size() == 0) begin
            chk("unexpected_word", 32'(lane_word(k)), 32'hFFFF_FFFF);
          end else begin
            chk("lane_data", 32'(lane_word(k)), 32'(lane_q[k].pop_front()));
          end
        end
      end
    end
  end

  task automatic drain_all();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 16'hFFFF);
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) lane_q[k].delete();
    m_ptr = 0;
  endtask

  initial begin
    tests = 0; fails = 0; m_ptr = 0;
    rst_n = 1'b0; i_valid = 1'b0; i_a = 16'h0000; i_sel = 4'd0;
    i_auto = 1'b0; i_bcast = 1'b0; i_ready = 16'h0000;
    #12;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_ptr", 32'(o_ptr), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    for (int k = 0; k < N; k++) chk("rst_data", 32'(lane_word(k)), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Explicit select with stalled consumers
    step(1'b1, 16'hA5A5, 4'd3, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'h1234, 4'd3, 1'b0, 1'b0, 16'h0000);
    chk("sel3_valid", 32'(o_valid), 32'h0008);
    chk("sel3_data", 32'(lane_word(3)), 32'hA5A5);
    chk("sel3_busy", 32'(o_ready), 32'h0);
    step(1'b1, 16'h4444, 4'd4, 1'b0, 1'b0, 16'h0000);
    chk("sel4_ready", 32'(o_ready), 32'h1);
    drain_all();

    // Same-cycle drain and load on lane 2
    step(1'b1, 16'h1111, 4'd2, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'h2222, 4'd2, 1'b0, 1'b0, 16'h0004);
    chk("dl_ready", 32'(o_ready), 32'h1);
    step(1'b0, 16'h0000, 4'd2, 1'b0, 1'b0, 16'h0000);
    chk("dl_valid2", 32'(o_valid[2]), 32'h1);
    chk("dl_data2", 32'(lane_word(2)), 32'h2222);
    drain_all();

    // Backpressure hold on lane 5
    step(1'b1, 16'hBEEF, 4'd5, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0000, 4'd5, 1'b0, 1'b0, 16'h0000);
      chk("hold_data5", 32'(lane_word(5)), 32'hBEEF);
      chk("hold_valid5", 32'(o_valid[5]), 32'h1);
    end
    drain_all();

    // Round robin, 17 back-to-back words with all consumers ready
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 16'(i), 4'd0, 1'b1, 1'b0, 16'hFFFF);
      chk("rr_ptr", 32'(o_ptr), 32'(i % 16));
      chk("rr_ready", 32'(o_ready), 32'h1);
    end
    drain_all();
    chk("rr_lane0_last", 32'(lane_word(0)), 32'd16);
    chk("rr_lane15", 32'(lane_word(15)), 32'd15);

    // Fill lanes with auto until pointer = 7 (ptr now 1), then async reset
    for (int i = 0; i < 6; i++) step(1'b1, 16'h7000 + 16'(i), 4'd0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 16'h0000);
    chk("pre_rst_ptr", 32'(o_ptr), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'h0);
    chk("arst_ptr", 32'(o_ptr), 32'h0);
    chk("arst_lane1", 32'(lane_word(1)), 32'h0);
    chk("arst_lane6", 32'(lane_word(6)), 32'h0);
    i_valid = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX_BROADCAST_EN
    // Broadcast waits for a stalled lane, then loads every lane
    step(1'b1, 16'h0101, 4'd9, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'h00FF, 4'd0, 1'b1, 1'b1, 16'h0000);
    chk("bc_blocked", 32'(o_ready), 32'h0);
    step(1'b1, 16'h00FF, 4'd0, 1'b1, 1'b1, 16'h0200);
    chk("bc_ready", 32'(o_ready), 32'h1);
    step(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 16'h0000);
    chk("bc_valid", 32'(o_valid), 32'hFFFF);
    chk("bc_ptr", 32'(o_ptr), 32'h0);
    for (int k = 0; k < N; k++) chk("bc_data", 32'(lane_word(k)), 32'h00FF);
    drain_all();
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0), 16'($urandom) | 16'($urandom));
    end
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
